// File: rtl/lpm_nco_sweep_pkg.sv
// Shared types and default widths for the NCO frequency-sweep controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lpm_nco_sweep_pkg;

  localparam int APR_DEF = 32;
  localparam int DWW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DWELL = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4
  } sweep_state_e;

endpackage

// File: rtl/lpm_nco_sweep_step.sv
// Next-point calculator: advances cur toward stop by step, clamping exactly onto stop.
// Latency: purely combinational.
// Backpressure: none.
module lpm_nco_sweep_step
  import lpm_nco_sweep_pkg::*;
#(
  parameter int APR = APR_DEF
) (
  input  logic [APR-1:0] cur_i,
  input  logic [APR-1:0] stop_i,
  input  logic [APR-1:0] step_i,
  input  logic           dir_i,    // 1 = ramp up, 0 = ramp down
  output logic [APR-1:0] nxt_o,
  output logic           final_o
);

  // Remaining distance to the stop word, one guard bit wide so it can never wrap.
  logic [APR:0] gap;
  logic         clamp;

  // Clamp to stop whenever one more step would reach or pass it; a negative gap
  // (cur already beyond stop) is treated as arrival as well.
  always_comb begin
    gap     = dir_i ? ({1'b0, stop_i} - {1'b0, cur_i})
                    : ({1'b0, cur_i} - {1'b0, stop_i});
    clamp   = gap[APR] || (gap <= {1'b0, step_i});
    if (clamp) begin
      nxt_o = stop_i;
    end else if (dir_i) begin
      nxt_o = cur_i + step_i;
    end else begin
      nxt_o = cur_i - step_i;
    end
    final_o = (cur_i == stop_i) || (step_i == '0);
  end

endmodule

// File: rtl/lpm_nco_sweep_ctrl.sv
// Linear frequency-sweep controller feeding the NCO phase increment; optional
// triangle mode under SWEEP_TRIANGLE_EN. Latency: start -> first point 2 edges,
// each point held max(dwell,1)+1 cycles. Backpressure: none; start ignored while busy.
module lpm_nco_sweep_ctrl
  import lpm_nco_sweep_pkg::*;
#(
  parameter int APR = APR_DEF,
  parameter int DWW = DWW_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic [APR-1:0] f_start,
  input  logic [APR-1:0] f_stop,
  input  logic [APR-1:0] f_step,
  input  logic [DWW-1:0] dwell,
  input  logic           cont,
  output logic [APR-1:0] phi_inc_o,
  output logic           step_stb,
  output logic           busy,
  output logic           done
);

  sweep_state_e   state_q, state_d;

  // Shadow copies of the sweep parameters, frozen at LOAD.
  logic [APR-1:0] stop_q;
  logic [APR-1:0] step_q;
  logic [DWW-1:0] dwell_q;       // already max(dwell,1)-1, ready to reload
  logic           dir_q;         // 1 = up
  logic [DWW-1:0] cnt_q;

  // Registered outputs.
  logic [APR-1:0] phi_q, phi_d;
  logic           stb_q, stb_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [APR-1:0] nxt;
  logic           is_final;
  logic           turn;          // bounce at the endpoint instead of finishing
  logic [DWW-1:0] dwell_ld;

`ifdef SWEEP_TRIANGLE_EN
  logic [APR-1:0] start_q;       // needed to swap endpoints on each turn
  assign turn = cont;
`else
  logic unused_cont;
  assign unused_cont = cont;
  assign turn        = 1'b0;
`endif

  // A dwell of zero behaves as one cycle.
  assign dwell_ld = (dwell == '0) ? '0 : dwell - DWW'(1);

  lpm_nco_sweep_step #(.APR(APR)) u_step (
    .cur_i   (phi_q),
    .stop_i  (stop_q),
    .step_i  (step_q),
    .dir_i   (dir_q),
    .nxt_o   (nxt),
    .final_o (is_final)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort beats every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start && !abort) state_d = LOAD;
      LOAD:  state_d = abort ? IDLE : DWELL;
      DWELL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = (is_final && !turn) ? DONE : STEP;
        end
      end
      STEP:  state_d = abort ? IDLE : DWELL;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values; an abort freezes phi and suppresses every pulse.
  always_comb begin
    phi_d  = phi_q;
    stb_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (!abort) begin
      case (state_q)
        LOAD: begin
          phi_d  = f_start;
          stb_d  = 1'b1;
          busy_d = 1'b1;
        end
        DWELL: busy_d = 1'b1;
        STEP: begin
          phi_d  = nxt;
          stb_d  = 1'b1;
          busy_d = 1'b1;
        end
        DONE: done_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phi_q  <= '0;
      stb_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      phi_q  <= phi_d;
      stb_q  <= stb_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Shadow parameters and dwell counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
`ifdef SWEEP_TRIANGLE_EN
      start_q <= '0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          stop_q  <= f_stop;
          step_q  <= f_step;
          dwell_q <= dwell_ld;
          cnt_q   <= dwell_ld;
          dir_q   <= (f_stop >= f_start);
`ifdef SWEEP_TRIANGLE_EN
          start_q <= f_start;
`endif
        end
        DWELL: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWW'(1);
          end
`ifdef SWEEP_TRIANGLE_EN
          else if (is_final && cont && !abort) begin
            start_q <= stop_q;
            stop_q  <= start_q;
            dir_q   <= !dir_q;
          end
`endif
        end
        STEP: cnt_q <= dwell_q;
        default: ;
      endcase
    end
  end

  assign phi_inc_o = phi_q;
  assign step_stb  = stb_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lpm_nco_sweep_ctrl.sv
// Bench for lpm_nco_sweep_ctrl: directed vector table, hand-written corner
// sequences and random sweeps compared against a point-list reference model.
module tb_lpm_nco_sweep_ctrl;

  localparam int APR = 32;
  localparam int DWW = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic           abort;
  logic [APR-1:0] f_start;
  logic [APR-1:0] f_stop;
  logic [APR-1:0] f_step;
  logic [DWW-1:0] dwell;
  logic           cont;
  logic [APR-1:0] phi_inc_o;
  logic           step_stb;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  longint exp_q[$];

  always #5 clk = ~clk;

  lpm_nco_sweep_ctrl #(.APR(APR), .DWW(DWW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .cont      (cont),
    .phi_inc_o (phi_inc_o),
    .step_stb  (step_stb),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [31:0] fs;
    logic [31:0] fp;
    logic [31:0] st;
    logic [15:0] dw;
    int          pts;
    logic [31:0] last;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the ordered list of frequency points a sweep must visit,
  // i.e. fs, fs+-k*st strictly before fp, then fp itself.
  task automatic build_ref(input logic [31:0] fs, input logic [31:0] fp, input logic [31:0] st);
    longint a, b, s, v;
    a = longint'(fs);
    b = longint'(fp);
    s = longint'(st);
    exp_q.delete();
    if (s == 0 || a == b) begin
      exp_q.push_back(a);
    end else if (b > a) begin
      v = a;
      while (v < b) begin
        exp_q.push_back(v);
        v = v + s;
      end
      exp_q.push_back(b);
    end else begin
      v = a;
      while (v > b) begin
        exp_q.push_back(v);
        v = v - s;
      end
      exp_q.push_back(b);
    end
  endtask

  // Run one full sweep and check every cycle against the reference timeline.
  task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fp, input logic [31:0] st,
                           input logic [15:0] dw, input bit poke,
                           output int n_stb, output logic [31:0] last);
    int d;
    int np;
    d = (dw == 0) ? 1 : int'(dw);
    build_ref(fs, fp, st);
    np = exp_q.size();
    n_stb = 0;
    last  = '0;
    @(negedge clk);
    f_start = fs; f_stop = fp; f_step = st; dwell = dw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", busy, 1'b0);
    for (int k = 0; k < np; k++) begin
      for (int c = 0; c < d + 1; c++) begin
        @(negedge clk);
        if (k == 0 && c == 0) begin
          f_start = $urandom; f_stop = $urandom; f_step = $urandom; dwell = 16'($urandom);
        end
        start = (poke && c == 0 && k < np - 1);
        chk("phi", phi_inc_o, 32'(exp_q[k]));
        chk("stb", step_stb, (c == 0));
        chk("busy", busy, 1'b1);
        chk("no_done", done, 1'b0);
        if (step_stb) n_stb++;
        last = phi_inc_o;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("busy_end", busy, 1'b0);
    chk("phi_hold", phi_inc_o, 32'(exp_q[np-1]));
    @(negedge clk);
    chk("done_once", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[9];
    int          n;
    logic [31:0] lst;
    logic [31:0] fs, fp, st, diff;
    logic [15:0] dw;
    logic [31:0] tri_seq[10];

    vt[0] = '{32'd100, 32'd130, 32'd10, 16'd3, 4, 32'd130};
    vt[1] = '{32'd50, 32'd20, 32'd12, 16'd2, 4, 32'd20};
    vt[2] = '{32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20, 16'd1, 2, 32'hFFFFFFFF};
    vt[3] = '{32'd77, 32'd500, 32'd0, 16'd2, 1, 32'd77};
    vt[4] = '{32'd100, 32'd130, 32'd10, 16'd0, 4, 32'd130};
    vt[5] = '{32'd100, 32'd130, 32'd10, 16'd1, 4, 32'd130};
    vt[6] = '{32'd42, 32'd42, 32'd5, 16'd2, 1, 32'd42};
    vt[7] = '{32'd0, 32'hFFFFFFFF, 32'h80000000, 16'd1, 3, 32'hFFFFFFFF};
    vt[8] = '{32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 16'd1, 2, 32'd0};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    repeat (3) @(negedge clk);
    chk("rst_phi", phi_inc_o, 32'd0);
    chk("rst_stb", step_stb, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vector table; the first entry also pokes start while busy.
    for (int i = 0; i < 9; i++) begin
      run_sweep(vt[i].fs, vt[i].fp, vt[i].st, vt[i].dw, (i == 0), n, lst);
      chk("vec_npts", n, vt[i].pts);
      chk("vec_last", lst, vt[i].last);
    end

    // Abort during the second dwell.
    @(negedge clk);
    f_start = 100; f_stop = 130; f_step = 10; dwell = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_pre_phi", phi_inc_o, 32'd110);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_phi", phi_inc_o, 32'd110);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
      chk("abort_hold", phi_inc_o, 32'd110);
    end

    // start together with abort in IDLE: nothing happens.
    f_start = 999;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("sa_busy", busy, 1'b0);
    chk("sa_stb", step_stb, 1'b0);
    chk("sa_phi", phi_inc_o, 32'd110);

    // Asynchronous reset in the middle of a dwell, then a fresh sweep.
    f_start = 100; f_stop = 130; f_step = 10; dwell = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("amid_phi", phi_inc_o, 32'd0);
    chk("amid_busy", busy, 1'b0);
    chk("amid_stb", step_stb, 1'b0);
    chk("amid_done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    run_sweep(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, n, lst);
    chk("post_rst_npts", n, 4);

    // Random sweeps against the reference point list.
    for (int r = 0; r < 25; r++) begin
      fs = $urandom;
      fp = ($urandom_range(0, 3) == 0) ? fs : $urandom;
      diff = (fs > fp) ? fs - fp : fp - fs;
      st = (diff >> $urandom_range(0, 3)) + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) st = 0;
      dw = 16'($urandom_range(0, 4));
      run_sweep(fs, fp, st, dw, r[0], n, lst);
      chk("rnd_npts", n, exp_q.size());
    end

`ifdef SWEEP_TRIANGLE_EN
    // Continuous triangle, then drop cont to finish at the next endpoint.
    tri_seq = '{32'd100, 32'd110, 32'd120, 32'd130, 32'd120,
                32'd110, 32'd100, 32'd110, 32'd120, 32'd130};
    @(negedge clk);
    f_start = 100; f_stop = 130; f_step = 10; dwell = 1; cont = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        if (k == 9 && c == 0) cont = 1'b0;
        chk("tri_phi", phi_inc_o, tri_seq[k]);
        chk("tri_stb", step_stb, (c == 0));
        chk("tri_done", done, 1'b0);
      end
    end
    @(negedge clk);
    chk("tri_end_done", done, 1'b1);
    chk("tri_end_busy", busy, 1'b0);
`else
    // Without triangle support cont has no effect.
    tri_seq[0] = 32'd130;
    cont = 1'b1;
    run_sweep(32'd100, 32'd130, 32'd10, 16'd1, 1'b0, n, lst);
    chk("cont_ign_last", lst, tri_seq[0]);
    cont = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
